// File: rtl/sram_arbiter.sv
// -----------------------------------------------------------------------------
// sram_arbiter
//
// Shares one single-port SRAM between the instruction-fetch port (read-only)
// and the data port (load/store). One access per cycle, round-robin on
// contention. After reset the whole array can optionally be zero-filled
// before any request is granted.
//
// Ports
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_if_req/i_if_addr   fetch read request (held until granted)
//   o_if_gnt             fetch accepted this cycle (combinational)
//   o_if_rvalid/o_if_rdata   fetch read data, one cycle after the grant
//   i_d_req/i_d_we/i_d_addr/i_d_wdata   data request (held until granted)
//   o_d_gnt              data accepted this cycle (combinational)
//   o_d_rvalid/o_d_rdata data read data, one cycle after a read grant
//   o_d_err              one-cycle pulse after an out-of-range data access
//   o_mem_cs/o_mem_we/o_mem_addr/o_mem_wdata   SRAM control pins
//   i_mem_rdata          SRAM registered read data
//   o_init_done          high once the array is ready (RUN state)
// -----------------------------------------------------------------------------
module sram_arbiter #(
   parameter int ADDR           = 8,
   parameter int WIDTH          = 32,
   parameter int LENGTH         = 256,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_if_req,
   input  logic [ADDR-1:0]  i_if_addr,
   output logic             o_if_gnt,
   output logic             o_if_rvalid,
   output logic [WIDTH-1:0] o_if_rdata,
   input  logic             i_d_req,
   input  logic             i_d_we,
   input  logic [ADDR-1:0]  i_d_addr,
   input  logic [WIDTH-1:0] i_d_wdata,
   output logic             o_d_gnt,
   output logic             o_d_rvalid,
   output logic [WIDTH-1:0] o_d_rdata,
   output logic             o_d_err,
   output logic             o_mem_cs,
   output logic             o_mem_we,
   output logic [ADDR-1:0]  o_mem_addr,
   output logic [WIDTH-1:0] o_mem_wdata,
   input  logic [WIDTH-1:0] i_mem_rdata,
   output logic             o_init_done
);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   localparam state_t          RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
   // One extra bit so LENGTH == 2**ADDR is representable in the range compare.
   localparam logic [ADDR:0]   LEN_EXT     = (ADDR+1)'(LENGTH);
   localparam logic [ADDR-1:0] LAST_ADDR   = ADDR'(LENGTH-1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [ADDR-1:0]  r_clr_cnt;
   logic             r_last_gnt_d;   // 1 = data port was granted most recently
   logic             r_if_rvalid;
   logic             r_d_rvalid;
   logic             r_if_oob;
   logic             r_d_oob;

   logic             w_if_gnt;
   logic             w_d_gnt;
   logic             w_if_oob;
   logic             w_d_oob;
   logic             w_mem_cs;
   logic             w_mem_we;
   logic [ADDR-1:0]  w_mem_addr;
   logic [WIDTH-1:0] w_mem_wdata;

   assign w_if_oob = ({1'b0, i_if_addr} >= LEN_EXT);
   assign w_d_oob  = ({1'b0, i_d_addr}  >= LEN_EXT);

   // Next state, arbitration and SRAM pin drive
   always_comb begin
      w_state_nxt = r_state;
      w_if_gnt    = 1'b0;
      w_d_gnt     = 1'b0;
      w_mem_cs    = 1'b0;
      w_mem_we    = 1'b0;
      w_mem_addr  = i_if_addr;
      w_mem_wdata = i_d_wdata;
      case (r_state)
         ST_CLEAR: begin
            w_mem_cs    = 1'b1;
            w_mem_we    = 1'b1;
            w_mem_addr  = r_clr_cnt;
            w_mem_wdata = {WIDTH{1'b0}};
            if (r_clr_cnt == LAST_ADDR) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_state_nxt = ST_CLEAR;
            end
         end
         ST_RUN: begin
            // On a tie the port that lost last time wins.
            w_if_gnt = i_if_req & (~i_d_req | r_last_gnt_d);
            w_d_gnt  = i_d_req & (~i_if_req | ~r_last_gnt_d);
            // Out-of-range accesses are granted but never reach the SRAM.
            if (w_d_gnt) begin
               w_mem_cs   = ~w_d_oob;
               w_mem_we   = i_d_we & ~w_d_oob;
               w_mem_addr = i_d_addr;
            end else if (w_if_gnt) begin
               w_mem_cs   = ~w_if_oob;
               w_mem_addr = i_if_addr;
            end else begin
               w_mem_cs   = 1'b0;
            end
         end
         default: begin
            w_state_nxt = RESET_STATE;
         end
      endcase
   end

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= RESET_STATE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Clear address counter, advances once per clear cycle
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_clr_cnt <= {ADDR{1'b0}};
      end else if (r_state == ST_CLEAR) begin
         r_clr_cnt <= r_clr_cnt + ADDR'(1'b1);
      end else begin
         r_clr_cnt <= r_clr_cnt;
      end
   end

   // Round-robin history; reset to "data" so fetch wins the first tie
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_last_gnt_d <= 1'b1;
      end else if (w_d_gnt) begin
         r_last_gnt_d <= 1'b1;
      end else if (w_if_gnt) begin
         r_last_gnt_d <= 1'b0;
      end else begin
         r_last_gnt_d <= r_last_gnt_d;
      end
   end

   // Read-valid and out-of-range flags for the cycle after the grant
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_if_rvalid <= 1'b0;
         r_d_rvalid  <= 1'b0;
         r_if_oob    <= 1'b0;
         r_d_oob     <= 1'b0;
      end else begin
         r_if_rvalid <= w_if_gnt;
         r_d_rvalid  <= w_d_gnt & ~i_d_we;
         r_if_oob    <= w_if_gnt & w_if_oob;
         // Doubles as the d_err pulse (reads and writes alike).
         r_d_oob     <= w_d_gnt & w_d_oob;
      end
   end

   assign o_if_gnt    = w_if_gnt;
   assign o_d_gnt     = w_d_gnt;
   assign o_mem_cs    = w_mem_cs;
   assign o_mem_we    = w_mem_we;
   assign o_mem_addr  = w_mem_addr;
   assign o_mem_wdata = w_mem_wdata;
   assign o_if_rvalid = r_if_rvalid;
   assign o_d_rvalid  = r_d_rvalid;
   assign o_d_err     = r_d_oob;
   assign o_if_rdata  = r_if_oob ? {WIDTH{1'b0}} : i_mem_rdata;
   assign o_d_rdata   = r_d_oob  ? {WIDTH{1'b0}} : i_mem_rdata;
   assign o_init_done = (r_state == ST_RUN);

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: instance A (LENGTH=256, clear on reset) and
// instance B (LENGTH=200, no clear), each with a small SRAM model.
module tb_sram_arbiter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- instance A ----------------
   logic        a_if_req, a_if_gnt, a_if_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid, a_d_err;
   logic        a_mem_cs, a_mem_we, a_init_done;
   logic [7:0]  a_if_addr, a_d_addr, a_mem_addr;
   logic [31:0] a_if_rdata, a_d_wdata, a_d_rdata, a_mem_wdata, a_mem_rdata;
   logic [31:0] sram_a [256];

   sram_arbiter #(.ADDR(8), .WIDTH(32), .LENGTH(256), .CLEAR_ON_RESET(1'b1)) dut_a (
      .i_clk(clk), .i_rst(rst),
      .i_if_req(a_if_req), .i_if_addr(a_if_addr), .o_if_gnt(a_if_gnt),
      .o_if_rvalid(a_if_rvalid), .o_if_rdata(a_if_rdata),
      .i_d_req(a_d_req), .i_d_we(a_d_we), .i_d_addr(a_d_addr), .i_d_wdata(a_d_wdata),
      .o_d_gnt(a_d_gnt), .o_d_rvalid(a_d_rvalid), .o_d_rdata(a_d_rdata), .o_d_err(a_d_err),
      .o_mem_cs(a_mem_cs), .o_mem_we(a_mem_we), .o_mem_addr(a_mem_addr),
      .o_mem_wdata(a_mem_wdata), .i_mem_rdata(a_mem_rdata), .o_init_done(a_init_done));

   always @(posedge clk) begin
      if (a_mem_cs) begin
         if (a_mem_we) sram_a[a_mem_addr] <= a_mem_wdata;
         else          a_mem_rdata <= sram_a[a_mem_addr];
      end
   end

   // ---------------- instance B ----------------
   logic        b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid, b_d_err;
   logic        b_mem_cs, b_mem_we, b_init_done;
   logic [7:0]  b_if_addr, b_d_addr, b_mem_addr;
   logic [31:0] b_if_rdata, b_d_wdata, b_d_rdata, b_mem_wdata, b_mem_rdata;
   logic [31:0] sram_b [256];

   sram_arbiter #(.ADDR(8), .WIDTH(32), .LENGTH(200), .CLEAR_ON_RESET(1'b0)) dut_b (
      .i_clk(clk), .i_rst(rst),
      .i_if_req(b_if_req), .i_if_addr(b_if_addr), .o_if_gnt(b_if_gnt),
      .o_if_rvalid(b_if_rvalid), .o_if_rdata(b_if_rdata),
      .i_d_req(b_d_req), .i_d_we(b_d_we), .i_d_addr(b_d_addr), .i_d_wdata(b_d_wdata),
      .o_d_gnt(b_d_gnt), .o_d_rvalid(b_d_rvalid), .o_d_rdata(b_d_rdata), .o_d_err(b_d_err),
      .o_mem_cs(b_mem_cs), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr),
      .o_mem_wdata(b_mem_wdata), .i_mem_rdata(b_mem_rdata), .o_init_done(b_init_done));

   always @(posedge clk) begin
      if (b_mem_cs) begin
         if (b_mem_we) sram_b[b_mem_addr] <= b_mem_wdata;
         else          b_mem_rdata <= sram_b[b_mem_addr];
      end
   end

   // Reference contents of instance A's array as seen by the requesters.
   logic [31:0] ref_a [256];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Clear sequence: 256 zero-writes at addresses 0..255, grants blocked,
   // then fetch wins the first tie and reads of 0/128/255 return zero.
   task automatic test_reset;
      logic [43:0] got_v, exp_v;
      rst = 1'b1;
      a_if_req = 1'b1; a_if_addr = 8'd0;
      a_d_req = 1'b1;  a_d_we = 1'b0; a_d_addr = 8'd128; a_d_wdata = 32'h0;
      tick(); tick();
      n_checks++;
      if ({a_init_done, b_init_done, a_if_rvalid, a_d_rvalid, a_d_err, b_d_err, a_if_gnt, a_d_gnt} !== 8'b0100_0000) begin
         n_fail++;
         $display("FAIL reset_values: got %b want 01000000",
                  {a_init_done, b_init_done, a_if_rvalid, a_d_rvalid, a_d_err, b_d_err, a_if_gnt, a_d_gnt});
      end
      rst = 1'b0;
      for (int c = 0; c < 256; c++) begin
         #1;
         got_v = {a_mem_cs, a_mem_we, a_mem_addr, a_mem_wdata, a_if_gnt | a_d_gnt, a_init_done};
         exp_v = {1'b1, 1'b1, 8'(c), 32'h0, 1'b0, 1'b0};
         n_checks++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL clear_cycle_%0d: got %h want %h", c, got_v, exp_v);
         end
         tick();
      end
      for (int i = 0; i < 256; i++) ref_a[i] = 32'h0;
      #1;
      n_checks++;
      if ({a_init_done, a_if_gnt, a_d_gnt, a_mem_cs, a_mem_we, a_mem_addr} !== {5'b11010, 8'd0}) begin
         n_fail++;
         $display("FAIL first_tie_fetch: got %b %b %b %b %b %h want 1 1 0 1 0 00",
                  a_init_done, a_if_gnt, a_d_gnt, a_mem_cs, a_mem_we, a_mem_addr);
      end
      tick();
      a_if_addr = 8'd255;
      #1;
      n_checks++;
      if ({a_d_gnt, a_if_gnt, a_mem_addr, a_if_rvalid, a_if_rdata} !== {2'b10, 8'd128, 1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL clear_read0: got gnt %b%b addr %h rvalid %b rdata %h want 10 80 1 0",
                  a_d_gnt, a_if_gnt, a_mem_addr, a_if_rvalid, a_if_rdata);
      end
      tick();
      a_d_req = 1'b0;
      #1;
      n_checks++;
      if ({a_if_gnt, a_mem_addr, a_d_rvalid, a_d_rdata} !== {1'b1, 8'd255, 1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL clear_read128: got gnt %b addr %h rvalid %b rdata %h want 1 ff 1 0",
                  a_if_gnt, a_mem_addr, a_d_rvalid, a_d_rdata);
      end
      tick();
      a_if_req = 1'b0;
      #1;
      n_checks++;
      if ({a_if_rvalid, a_if_rdata} !== {1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL clear_read255: got rvalid %b rdata %h want 1 0", a_if_rvalid, a_if_rdata);
      end
      tick();
   endtask

   // Preload addr 5 through the data port, then a lone fetch reads it back.
   task automatic test_fetch_only;
      a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 8'd5; a_d_wdata = 32'hDEADBEEF;
      #1;
      n_checks++;
      if ({a_d_gnt, a_mem_cs, a_mem_we, a_mem_addr, a_mem_wdata} !== {3'b111, 8'd5, 32'hDEADBEEF}) begin
         n_fail++;
         $display("FAIL preload_write: got %b%b%b %h %h want 111 05 deadbeef",
                  a_d_gnt, a_mem_cs, a_mem_we, a_mem_addr, a_mem_wdata);
      end
      tick();
      ref_a[5] = 32'hDEADBEEF;
      a_d_req = 1'b0;
      a_if_req = 1'b1; a_if_addr = 8'd5;
      #1;
      n_checks++;
      if ({a_d_rvalid, a_d_err, a_if_gnt, a_d_gnt, a_mem_cs, a_mem_we, a_mem_addr} !== {6'b001010, 8'd5}) begin
         n_fail++;
         $display("FAIL fetch_grant: got %b%b%b%b%b%b %h want 001010 05",
                  a_d_rvalid, a_d_err, a_if_gnt, a_d_gnt, a_mem_cs, a_mem_we, a_mem_addr);
      end
      tick();
      a_if_req = 1'b0;
      #1;
      n_checks++;
      if ({a_if_rvalid, a_if_rdata, a_if_gnt, a_mem_cs} !== {1'b1, 32'hDEADBEEF, 2'b00}) begin
         n_fail++;
         $display("FAIL fetch_rdata: got %b %h %b%b want 1 deadbeef 00",
                  a_if_rvalid, a_if_rdata, a_if_gnt, a_mem_cs);
      end
      tick();
      n_checks++;
      if (a_if_rvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_rvalid_drop: got %b want 0", a_if_rvalid);
      end
   endtask

   // Write then read the same address in consecutive grant cycles.
   task automatic test_write_read;
      a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 8'd10; a_d_wdata = 32'h12345678;
      #1;
      n_checks++;
      if ({a_d_gnt, a_mem_we, a_mem_addr} !== {2'b11, 8'd10}) begin
         n_fail++;
         $display("FAIL wr_grant: got %b%b %h want 11 0a", a_d_gnt, a_mem_we, a_mem_addr);
      end
      tick();
      ref_a[10] = 32'h12345678;
      a_d_we = 1'b0;
      #1;
      n_checks++;
      if ({a_d_rvalid, a_d_gnt, a_mem_we, a_mem_cs} !== 4'b0101) begin
         n_fail++;
         $display("FAIL rd_after_wr_grant: got %b%b%b%b want 0101", a_d_rvalid, a_d_gnt, a_mem_we, a_mem_cs);
      end
      tick();
      a_d_req = 1'b0;
      #1;
      n_checks++;
      if ({a_d_rvalid, a_d_rdata} !== {1'b1, 32'h12345678}) begin
         n_fail++;
         $display("FAIL rd_after_wr_data: got %b %h want 1 12345678", a_d_rvalid, a_d_rdata);
      end
      tick();
   endtask

   // Continuous contention: grants alternate F,D,F,D... starting with fetch.
   task automatic test_contention;
      logic ef;
      a_if_req = 1'b1; a_if_addr = 8'd5;
      a_d_req = 1'b1;  a_d_we = 1'b0; a_d_addr = 8'd10;
      for (int i = 0; i < 9; i++) begin
         if (i == 8) begin
            a_if_req = 1'b0; a_d_req = 1'b0;
         end
         #1;
         ef = (i % 2 == 0);
         if (i < 8) begin
            n_checks++;
            if ({a_if_gnt, a_d_gnt, a_mem_addr} !== {ef, ~ef, (ef ? 8'd5 : 8'd10)}) begin
               n_fail++;
               $display("FAIL contend_gnt_%0d: got %b%b %h want %b%b %h", i, a_if_gnt, a_d_gnt,
                        a_mem_addr, ef, ~ef, (ef ? 8'd5 : 8'd10));
            end
         end
         if (i > 0) begin
            n_checks++;
            if (!ef && {a_if_rvalid, a_d_rvalid, a_if_rdata} !== {2'b10, 32'hDEADBEEF}) begin
               n_fail++;
               $display("FAIL contend_fetch_data_%0d: got %b%b %h want 10 deadbeef", i,
                        a_if_rvalid, a_d_rvalid, a_if_rdata);
            end else if (ef && {a_if_rvalid, a_d_rvalid, a_d_rdata} !== {2'b01, 32'h12345678}) begin
               n_fail++;
               $display("FAIL contend_data_data_%0d: got %b%b %h want 01 12345678", i,
                        a_if_rvalid, a_d_rvalid, a_d_rdata);
            end
         end
         tick();
      end
   endtask

   // Instance B (LENGTH=200): boundary in range, out-of-range reads/writes.
   task automatic test_oob;
      logic [31:0] old_v;
      b_d_req = 1'b1; b_d_we = 1'b1; b_d_addr = 8'd199; b_d_wdata = 32'h11112222;
      #1;
      n_checks++;
      if ({b_init_done, b_d_gnt, b_mem_cs, b_mem_we} !== 4'b1111) begin
         n_fail++;
         $display("FAIL oob_w199: got %b%b%b%b want 1111", b_init_done, b_d_gnt, b_mem_cs, b_mem_we);
      end
      tick();
      b_d_we = 1'b0;
      tick();
      b_d_addr = 8'd250;
      #1;
      n_checks++;
      if ({b_d_rvalid, b_d_rdata, b_d_err, b_d_gnt, b_mem_cs} !== {1'b1, 32'h11112222, 3'b010}) begin
         n_fail++;
         $display("FAIL oob_r199: got %b %h err %b gnt %b cs %b want 1 11112222 0 1 0",
                  b_d_rvalid, b_d_rdata, b_d_err, b_d_gnt, b_mem_cs);
      end
      tick();
      b_d_addr = 8'd200;
      #1;
      n_checks++;
      if ({b_d_rvalid, b_d_rdata, b_d_err, b_mem_cs} !== {1'b1, 32'h0, 2'b10}) begin
         n_fail++;
         $display("FAIL oob_r250: got %b %h err %b cs %b want 1 0 1 0", b_d_rvalid, b_d_rdata, b_d_err, b_mem_cs);
      end
      tick();
      old_v = sram_b[250];
      b_d_we = 1'b1; b_d_addr = 8'd250; b_d_wdata = 32'hFFFFFFFF;
      #1;
      n_checks++;
      if ({b_d_rvalid, b_d_rdata, b_d_err, b_d_gnt, b_mem_cs} !== {1'b1, 32'h0, 3'b110}) begin
         n_fail++;
         $display("FAIL oob_r200: got %b %h err %b gnt %b cs %b want 1 0 1 1 0",
                  b_d_rvalid, b_d_rdata, b_d_err, b_d_gnt, b_mem_cs);
      end
      tick();
      b_d_req = 1'b0;
      b_if_req = 1'b1; b_if_addr = 8'd220;
      #1;
      n_checks++;
      if ({b_d_rvalid, b_d_err, b_if_gnt, b_mem_cs} !== 4'b0110 || sram_b[250] !== old_v) begin
         n_fail++;
         $display("FAIL oob_w250: got rvalid %b err %b fgnt %b cs %b mem %h want 0 1 1 0 %h",
                  b_d_rvalid, b_d_err, b_if_gnt, b_mem_cs, sram_b[250], old_v);
      end
      tick();
      b_if_req = 1'b0;
      #1;
      n_checks++;
      if ({b_if_rvalid, b_if_rdata, b_d_err} !== {1'b1, 32'h0, 1'b0}) begin
         n_fail++;
         $display("FAIL oob_fetch220: got %b %h err %b want 1 0 0", b_if_rvalid, b_if_rdata, b_d_err);
      end
      tick();
   endtask

   // Random traffic on instance A checked against a request-level model.
   task automatic test_random;
      logic        f_act, d_act, d_we_m, last_d, pf, pd;
      logic [7:0]  f_ad, d_ad;
      logic [31:0] d_wd, pf_data, pd_data;
      int          winner, f_wait, d_wait, max_wait;
      f_act = 1'b0; d_act = 1'b0; pf = 1'b0; pd = 1'b0;
      pf_data = 32'h0; pd_data = 32'h0; d_we_m = 1'b0; f_ad = 8'd0; d_ad = 8'd0; d_wd = 32'h0;
      last_d = 1'b1;   // contention test ended on a data grant
      f_wait = 0; d_wait = 0; max_wait = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!f_act && $urandom_range(0, 1) == 1) begin
            f_act = 1'b1;
            f_ad  = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 15));
         end
         if (!d_act && $urandom_range(0, 1) == 1) begin
            d_act  = 1'b1;
            d_we_m = 1'($urandom_range(0, 1));
            d_ad   = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(0, 15));
            d_wd   = $urandom;
         end
         a_if_req = f_act; a_if_addr = f_ad;
         a_d_req = d_act;  a_d_we = d_we_m; a_d_addr = d_ad; a_d_wdata = d_wd;
         #1;
         if (f_act && d_act) winner = last_d ? 1 : 2;
         else if (f_act)     winner = 1;
         else if (d_act)     winner = 2;
         else                winner = 0;
         n_checks++;
         if ({a_if_gnt, a_d_gnt} !== {winner == 1, winner == 2} ||
             (winner == 1 && a_mem_addr !== f_ad) || (winner == 2 && a_mem_addr !== d_ad)) begin
            n_fail++;
            $display("FAIL rand_gnt_%0d: got %b%b addr %h want winner %0d", cyc, a_if_gnt, a_d_gnt, a_mem_addr, winner);
         end
         n_checks++;
         if (a_if_rvalid !== pf || (pf && a_if_rdata !== pf_data)) begin
            n_fail++;
            $display("FAIL rand_fetch_rd_%0d: got %b %h want %b %h", cyc, a_if_rvalid, a_if_rdata, pf, pf_data);
         end
         n_checks++;
         if (a_d_rvalid !== pd || (pd && a_d_rdata !== pd_data) || a_d_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rand_data_rd_%0d: got %b %h err %b want %b %h 0", cyc, a_d_rvalid, a_d_rdata, a_d_err, pd, pd_data);
         end
         pf = 1'b0; pd = 1'b0;
         if (winner == 1) begin
            pf = 1'b1; pf_data = ref_a[f_ad]; f_act = 1'b0; last_d = 1'b0;
         end else if (winner == 2) begin
            if (d_we_m) ref_a[d_ad] = d_wd;
            else begin pd = 1'b1; pd_data = ref_a[d_ad]; end
            d_act = 1'b0; last_d = 1'b1;
         end
         f_wait = f_act ? f_wait + 1 : 0;
         d_wait = d_act ? d_wait + 1 : 0;
         if (f_wait > max_wait) max_wait = f_wait;
         if (d_wait > max_wait) max_wait = d_wait;
         tick();
      end
      a_if_req = 1'b0; a_d_req = 1'b0;
      #1;
      n_checks++;
      if (a_if_rvalid !== pf || a_d_rvalid !== pd || max_wait > 1) begin
         n_fail++;
         $display("FAIL rand_tail: got rvalid %b%b max_wait %0d want %b%b <=1", a_if_rvalid, a_d_rvalid, max_wait, pf, pd);
      end
      tick();
   endtask

   // Reset during an access and during the clear restarts everything.
   task automatic test_reset_mid;
      a_if_req = 1'b1; a_if_addr = 8'd10;
      tick();
      rst = 1'b1;
      #1;
      n_checks++;
      if ({a_if_rvalid, a_init_done, a_if_gnt, a_mem_we, a_mem_addr} !== {4'b0001, 8'd0}) begin
         n_fail++;
         $display("FAIL rst_mid_access: got %b%b%b%b %h want 0001 00", a_if_rvalid, a_init_done, a_if_gnt, a_mem_we, a_mem_addr);
      end
      tick();
      rst = 1'b0;
      repeat (100) tick();
      n_checks++;
      if ({a_mem_addr, a_init_done} !== {8'd100, 1'b0}) begin
         n_fail++;
         $display("FAIL clear_at_100: got %h %b want 64 0", a_mem_addr, a_init_done);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({a_mem_addr, a_mem_we, a_init_done} !== {8'd0, 2'b10}) begin
         n_fail++;
         $display("FAIL rst_mid_clear: got %h %b%b want 00 10", a_mem_addr, a_mem_we, a_init_done);
      end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 256; c++) begin
         #1;
         n_checks++;
         if ({a_mem_cs, a_mem_we, a_mem_addr, a_if_gnt} !== {2'b11, 8'(c), 1'b0}) begin
            n_fail++;
            $display("FAIL reclear_%0d: got %b%b %h gnt %b want 11 %h 0", c, a_mem_cs, a_mem_we, a_mem_addr, a_if_gnt, 8'(c));
         end
         tick();
      end
      #1;
      n_checks++;
      if ({a_init_done, a_if_gnt} !== 2'b11) begin
         n_fail++;
         $display("FAIL reclear_done: got %b%b want 11", a_init_done, a_if_gnt);
      end
      tick();
      a_if_req = 1'b0;
      #1;
      n_checks++;
      if ({a_if_rvalid, a_if_rdata} !== {1'b1, 32'h0}) begin
         n_fail++;
         $display("FAIL reclear_read10: got %b %h want 1 0", a_if_rvalid, a_if_rdata);
      end
      tick();
   endtask

   initial begin
      rst = 1'b1;
      a_if_req = 1'b0; a_if_addr = 8'd0; a_d_req = 1'b0; a_d_we = 1'b0; a_d_addr = 8'd0; a_d_wdata = 32'h0;
      b_if_req = 1'b0; b_if_addr = 8'd0; b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = 8'd0; b_d_wdata = 32'h0;
      test_reset();
      test_fetch_only();
      test_write_read();
      test_contention();
      test_oob();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
